// File: rtl/button_debounce_pkg.sv
// Shared types and helpers for the push-button debouncer.
// FSM encoding is fixed so waveforms stay readable: the MSB is the settled level.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    HIGH      = 2'b11,
    WAIT_LOW  = 2'b10
  } state_t;

  // Terminal count of a width-bit stability counter (2^width - 1).
  function automatic logic [31:0] cnt_max(input int unsigned width);
    logic [32:0] span;
    span = 33'd1 << width;
    return 32'(span - 33'd1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser, asynchronous active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchroniser, stability-counter FSM, level and edge strobes.
// Build option BUTTON_DEBOUNCE_INVERT_EN treats the pin as active-low.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic bouncing
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));

  logic pin;
  logic s2;

`ifdef BUTTON_DEBOUNCE_INVERT_EN
  assign pin = ~button_raw;
`else
  assign pin = button_raw;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pin),
    .q     (s2)
  );

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic                 level_next, press_next, release_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE_LOW;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      btn_level   <= level_next;
      btn_press   <= press_next;
      btn_release <= release_next;
    end
  end

  // Any reversal during qualification aborts with no partial credit kept.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    level_next   = btn_level;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (s2) begin
          state_next = WAIT_HIGH;
          cnt_next   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_next = IDLE_LOW;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next = HIGH;
          cnt_next   = '0;
          level_next = 1'b1;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_WIDTH'(1);
        end
      end
      HIGH: begin
        if (!s2) begin
          state_next = WAIT_LOW;
          cnt_next   = '0;
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next   = IDLE_LOW;
          cnt_next     = '0;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_next = IDLE_LOW;
        cnt_next   = '0;
      end
    endcase
  end

  assign bouncing = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce (CNT_WIDTH=4): strobe scoreboard plus level/state probes.
// Honours BUTTON_DEBOUNCE_INVERT_EN by driving the physical pin polarity.
module tb_button_debounce;

  localparam int LAT = 19;  // set at negedge e -> sampled at e+1 -> strobe at e+1+18

`ifdef BUTTON_DEBOUNCE_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  localparam logic [1:0] K_PRESS   = 2'b10;
  localparam logic [1:0] K_RELEASE = 2'b01;

  logic clk = 1'b0;
  logic rst_n;
  logic button_raw;
  logic btn_level, btn_press, btn_release, bouncing;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [1:0] kind;
    int         at;
  } exp_t;
  exp_t sb[$];

  button_debounce #(.CNT_WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .button_raw  (button_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .bouncing    (bouncing)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  function automatic logic phys(input logic v);
    return v ^ INV;
  endfunction

  task automatic drive(input logic v, input int n);
    button_raw = phys(v);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_to(input int e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  task automatic expect_event(input logic [1:0] kind);
    exp_t x;
    x.kind = kind;
    x.at   = edge_cnt + LAT;
    sb.push_back(x);
  endtask

  // Strobe monitor: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (btn_press || btn_release)) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'({btn_press, btn_release}), 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("strobe_kind", 32'({btn_press, btn_release}), 32'(x.kind));
        check("strobe_edge", 32'(edge_cnt), 32'(x.at));
        check("strobe_level", 32'(btn_level), (x.kind == K_PRESS) ? 32'd1 : 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    rst_n      = 1'b0;
    button_raw = phys(1'b1);
    repeat (3) @(negedge clk);
    check("rst_level", 32'(btn_level), 32'd0);
    check("rst_press", 32'(btn_press), 32'd0);
    check("rst_release", 32'(btn_release), 32'd0);
    check("rst_bouncing", 32'(bouncing), 32'd0);
    button_raw = phys(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Clean press
    e = edge_cnt;
    expect_event(K_PRESS);
    button_raw = phys(1'b1);
    wait_to(e + 2);
    check("press_bounce_pre", 32'(bouncing), 32'd0);
    wait_to(e + 3);
    check("press_bounce_start", 32'(bouncing), 32'd1);
    wait_to(e + 18);
    check("press_bounce_end", 32'(bouncing), 32'd1);
    check("press_level_early", 32'(btn_level), 32'd0);
    wait_to(e + 19);
    check("press_level", 32'(btn_level), 32'd1);
    check("press_bounce_done", 32'(bouncing), 32'd0);
    wait_to(e + 24);
    check("press_sb_empty", 32'(sb.size()), 32'd0);

    // 10-cycle low glitch from HIGH must not release
    drive(1'b0, 10);
    drive(1'b1, 30);
    check("glitch_level", 32'(btn_level), 32'd1);
    check("glitch_state", 32'(dut.state), 32'(2'b11));
    check("glitch_sb_empty", 32'(sb.size()), 32'd0);

    // Clean release
    e = edge_cnt;
    expect_event(K_RELEASE);
    button_raw = phys(1'b0);
    wait_to(e + 18);
    check("release_level_early", 32'(btn_level), 32'd1);
    wait_to(e + 19);
    check("release_level", 32'(btn_level), 32'd0);
    wait_to(e + 24);
    check("release_sb_empty", 32'(sb.size()), 32'd0);

    // Bounce reject: 1x5, 0x2, 1x6, then 0 held
    drive(1'b1, 5);
    drive(1'b0, 2);
    drive(1'b1, 6);
    drive(1'b0, 30);
    check("reject_level", 32'(btn_level), 32'd0);
    check("reject_state", 32'(dut.state), 32'(2'b00));
    check("reject_cnt", 32'(dut.cnt), 32'd0);
    check("reject_sb_empty", 32'(sb.size()), 32'd0);

    // Bounce then settle: four toggles in eight cycles, then 1 held
    drive(1'b1, 2);
    drive(1'b0, 2);
    drive(1'b1, 2);
    drive(1'b0, 2);
    e = edge_cnt;
    expect_event(K_PRESS);
    button_raw = phys(1'b1);
    wait_to(e + 18);
    check("settle_level_early", 32'(btn_level), 32'd0);
    wait_to(e + 24);
    check("settle_level", 32'(btn_level), 32'd1);
    check("settle_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset mid-cycle from HIGH, key held through release
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_level", 32'(btn_level), 32'd0);
    check("async_rst_state", 32'(dut.state), 32'(2'b00));
    @(negedge clk);
    rst_n = 1'b1;
    e = edge_cnt;
    expect_event(K_PRESS);
    wait_to(e + 18);
    check("held_level_early", 32'(btn_level), 32'd0);
    wait_to(e + 24);
    check("held_level", 32'(btn_level), 32'd1);
    check("held_sb_empty", 32'(sb.size()), 32'd0);

    // Return low, then reset during WAIT_HIGH qualification
    e = edge_cnt;
    expect_event(K_RELEASE);
    button_raw = phys(1'b0);
    wait_to(e + 24);
    check("midq_pre_level", 32'(btn_level), 32'd0);
    e = edge_cnt;
    button_raw = phys(1'b1);
    wait_to(e + 10);
    check("midq_bouncing", 32'(bouncing), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midq_rst_bouncing", 32'(bouncing), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    e = edge_cnt;
    expect_event(K_PRESS);
    wait_to(e + 18);
    check("midq_level_early", 32'(btn_level), 32'd0);
    wait_to(e + 24);
    check("midq_level", 32'(btn_level), 32'd1);
    check("midq_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
